decode_stage_pipe: RTL and testbench

- Parametrised RV32I decode stage for the in-order core, sitting between fetch and execute.
- Contains the architectural register file with a write-back port and write-through bypass, plus immediate generation for all RV32I formats.
- Holds the ID/EX pipeline register behind a valid/ready handshake.
- Detects load-use hazards and inserts one bubble; supports a synchronous flush for branch redirect.

---
 rtl/rv_decode_pkg.sv | 54 +++++
 rtl/decode_stage_pipe_if.sv | 41 ++++
 rtl/rv_regfile.sv | 37 +++
 rtl/decode_stage_pipe.sv | 84 ++++++++
 tb/tb_decode_stage_pipe.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, field positions
// and the small decode helpers used by the decode stage.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    function automatic imm_type_e imm_sel(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            default:                        return IMM_NONE;
        endcase
    endfunction

    function automatic logic [31:0] imm32_gen(input logic [31:0] i, input imm_type_e t);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic rs1_used(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic rs2_used(input logic [6:0] opc);
        return opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch/write-back/execute signal bundle of the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_pipe_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RW = $clog2(NREGS);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            wb_we;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [RW-1:0]   out_rd;
    logic [RW-1:0]   out_rs1;
    logic [RW-1:0]   out_rs2;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;

    modport master (
        output in_valid, in_instr, in_pc, flush, wb_we, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_funct7
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, wb_we, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_funct7
    );
endinterface

// File: rtl/rv_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, optional write-through bypass.
module rv_regfile #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_WB = 1,
    parameter int RW        = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RW-1:0]   ra1,
    input  logic [RW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [RW-1:0] ra);
        if (ra == '0)                                  return '0;
        else if (BYPASS_WB != 0 && we && wa == ra)     return wd;
        else                                           return regs[ra];
    endfunction

    assign rd1 = rd_port(ra1);
    assign rd2 = rd_port(ra2);
endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: register read, immediate generation, load-use stall and
// the ID/EX pipeline register behind a valid/ready handshake.
module decode_stage_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_WB = 1,
    parameter int HAZARD_EN = 1
) (
    input logic clk,
    input logic rst,
    decode_stage_pipe_if.slave bus
);
    localparam int RW = $clog2(NREGS);

    logic [31:0]     instr;
    logic [6:0]      opc;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic            hazard, accept;

    assign instr = bus.in_instr;
    assign opc   = instr[OPC_LSB +: 7];
    assign rd    = instr[RD_LSB  +: RW];
    assign rs1   = instr[RS1_LSB +: RW];
    assign rs2   = instr[RS2_LSB +: RW];
    assign imm   = XLEN'($signed(imm32_gen(instr, imm_sel(opc))));

    rv_regfile #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS_WB(BYPASS_WB)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_data),
        .rd2 (rs2_data),
        .we  (bus.wb_we),
        .wa  (bus.wb_rd),
        .wd  (bus.wb_data)
    );

    // A load result is not available until after EX/MEM, so a dependent
    // instruction waits one cycle while the load drains.
    always_comb begin
        hazard = (HAZARD_EN != 0) && bus.out_valid && bus.out_opcode == OPC_LOAD
              && bus.out_rd != '0 && bus.in_valid
              && ((rs1_used(opc) && rs1 == bus.out_rd) || (rs2_used(opc) && rs2 == bus.out_rd));
    end

    assign bus.in_ready = bus.flush | ((!bus.out_valid | bus.out_ready) & !hazard);
    assign accept       = bus.in_valid & bus.in_ready & !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= '0;
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
            bus.out_imm      <= '0;
            bus.out_rd       <= '0;
            bus.out_rs1      <= '0;
            bus.out_rs2      <= '0;
            bus.out_opcode   <= '0;
            bus.out_funct3   <= '0;
            bus.out_funct7   <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid    <= 1'b1;
            bus.out_pc       <= bus.in_pc;
            bus.out_rs1_data <= rs1_data;
            bus.out_rs2_data <= rs2_data;
            bus.out_imm      <= imm;
            bus.out_rd       <= rd;
            bus.out_rs1      <= rs1;
            bus.out_rs2      <= rs2;
            bus.out_opcode   <= opc;
            bus.out_funct3   <= instr[F3_LSB +: 3];
            bus.out_funct7   <= instr[F7_LSB +: 7];
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: expected ID/EX contents are queued at
// accept time and checked by a monitor whenever execute consumes an entry.
module tb_decode_stage_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    decode_stage_pipe_if #(.XLEN(32), .NREGS(32)) bus();

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS_WB(1), .HAZARD_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc, r1d, r2d, imm,
                                input logic [4:0] rd, rs1, rs2,
                                input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        exp_t e;
        e = '{pc:pc, rs1_data:r1d, rs2_data:r2d, imm:imm, rd:rd, rs1:rs1, rs2:rs2,
              opc:opc, f3:f3, f7:f7};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present one instruction until accepted; expectation queued at the accepting edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                        output int waited, output logic ov_at_acc);
        bit done;
        done = 0; waited = 0; ov_at_acc = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_pc = pc;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                ov_at_acc = bus.out_valid;
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: instr %h never accepted", instr);
        end
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_we = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
        @(posedge clk); #1;
        bus.wb_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int   w;
        logic ov;
        bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.flush = 0;
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.out_ready = 1;
        fork
            begin : stim
                idle(3);
                rst = 1'b0;
                @(negedge clk);
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
                chk("rst_out_pc", bus.out_pc, 32'd0);
                chk("rst_out_imm", bus.out_imm, 32'd0);
                @(posedge clk); #1;

                // register read after write
                wb(5'd5, 32'hDEADBEEF);
                send(32'h000280B3, 32'h100, mk(32'h100, 32'hDEADBEEF, 0, 0, 1, 5, 0, 7'h33, 0, 0), w, ov);

                // same-cycle write-through bypass
                bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h12345678;
                send(32'h000280B3, 32'h104, mk(32'h104, 32'h12345678, 0, 0, 1, 5, 0, 7'h33, 0, 0), w, ov);
                bus.wb_we = 1'b0;

                // x0 writes ignored, both earlier and same cycle
                wb(5'd0, 32'h5);
                bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h5;
                send(32'h000000B3, 32'h108, mk(32'h108, 0, 0, 0, 1, 0, 0, 7'h33, 0, 0), w, ov);
                bus.wb_we = 1'b0;

                // load-use: exactly one stall cycle and one bubble
                wb(5'd2, 32'hCAFE0002);
                send(32'h00012103, 32'h10C, mk(32'h10C, 32'hCAFE0002, 0, 0, 2, 2, 0, 7'h03, 2, 0), w, ov);
                send(32'h000101B3, 32'h110, mk(32'h110, 32'hCAFE0002, 0, 0, 3, 2, 0, 7'h33, 0, 0), w, ov);
                chk("loaduse_stall_cycles", 32'(w), 32'd1);
                chk("loaduse_bubble", 32'(ov), 32'd0);

                // load to x0 never stalls
                send(32'h00012003, 32'h114, mk(32'h114, 32'hCAFE0002, 0, 0, 0, 2, 0, 7'h03, 2, 0), w, ov);
                send(32'h000001B3, 32'h118, mk(32'h118, 0, 0, 0, 3, 0, 0, 7'h33, 0, 0), w, ov);
                chk("load_x0_no_stall", 32'(w), 32'd0);
                idle(2);

                // hold with out_ready low
                bus.out_ready = 1'b0;
                send(32'hFFF00093, 32'h200, mk(32'h200, 0, 0, 32'hFFFFFFFF, 1, 0, 31, 7'h13, 0, 7'h7F), w, ov);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("hold_out_imm", bus.out_imm, 32'hFFFFFFFF);
                    chk("hold_out_pc", bus.out_pc, 32'h200);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
                idle(1);
                @(negedge clk);
                chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
                @(posedge clk); #1;

                // flush kills both held and incoming instructions
                bus.out_ready = 1'b0;
                send(32'h000280B3, 32'h300, mk(32'h300, 32'h12345678, 0, 0, 1, 5, 0, 7'h33, 0, 0), w, ov);
                bus.in_valid = 1'b1; bus.in_instr = 32'hFFF00093; bus.in_pc = 32'h304; bus.flush = 1'b1;
                @(negedge clk);
                chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
                @(posedge clk); #1;
                bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
                void'(sb.pop_back());
                @(negedge clk);
                chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
                @(posedge clk); #1;

                // immediate formats, back to back
                send(32'hFFDFF06F, 32'h308, mk(32'h308, 0, 0, 32'hFFFFFFFC, 0, 31, 29, 7'h6F, 7, 7'h7F), w, ov);
                chk("jal_no_wait", 32'(w), 32'd0);
                send(32'h123450B7, 32'h30C, mk(32'h30C, 0, 0, 32'h12345000, 1, 8, 3, 7'h37, 5, 7'h09), w, ov);
                chk("lui_no_wait", 32'(w), 32'd0);
                send(32'h0020A423, 32'h310, mk(32'h310, 0, 32'hCAFE0002, 32'd8, 8, 1, 2, 7'h23, 2, 0), w, ov);
                chk("sw_no_wait", 32'(w), 32'd0);
                send(32'hFE000CE3, 32'h314, mk(32'h314, 0, 0, 32'hFFFFFFF8, 25, 0, 0, 7'h63, 0, 7'h7F), w, ov);
                chk("beq_no_wait", 32'(w), 32'd0);
                idle(3);
                chk("scoreboard_empty", 32'(sb.size()), 32'd0);
            end
            begin : mon
                forever begin
                    @(negedge clk);
                    if (!rst && bus.out_valid && bus.out_ready) begin
                        exp_t act, e;
                        act = '{pc:bus.out_pc, rs1_data:bus.out_rs1_data, rs2_data:bus.out_rs2_data,
                                imm:bus.out_imm, rd:bus.out_rd, rs1:bus.out_rs1, rs2:bus.out_rs2,
                                opc:bus.out_opcode, f3:bus.out_funct3, f7:bus.out_funct7};
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_output: got %h expected nothing", act);
                        end else begin
                            e = sb.pop_front();
                            if (act !== e) begin
                                n_fail++;
                                $display("FAIL idex_fields pc=%h: got %h expected %h", e.pc, act, e);
                            end
                        end
                    end
                end
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
